icache: RTL
===========

# icache

Direct-mapped, one-word-per-line instruction cache between the instruction-fetch stage and `mem_ctrl`. It answers IF fetch requests from local storage on a hit. On a miss it issues one 4-byte fetch to `mem_ctrl`, fills the line, and forwards the word. It accepts an IF flush (branch redirect) at any time without corrupting the in-flight `mem_ctrl` transaction.

## Interface
- `INDEX_W`, default 6: index bits; the cache holds 2^INDEX_W lines of 32 bits.
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst`  input  1  synchronous, active-low reset.
- `rdy`  input  1  global enable; low = pause, all state frozen.
- `if_req`  input  1  IF fetch request; held with a stable `if_addr` until `if_valid` or `if_flush`.
- `if_addr`  input  32  fetch PC; bits [1:0] ignored.
- `if_flush`  input  1  discard the current request (redirect).
- `if_valid`  output  1  one-cycle pulse; `if_inst` is valid.
- `if_inst`  output  32 (`ISZ`)  fetched instruction.
- `mc_req`  output  1  fetch request to `mem_ctrl`; held until `mc_flag`.
- `mc_addr`  output  32  word-aligned fetch address.
- `mc_flag`  input  1  `mem_ctrl` one-cycle done pulse.
- `mc_inst`  input  32  word from `mem_ctrl`; valid with `mc_flag`.

## Operation
- Address split: index = `if_addr[INDEX_W+1:2]`; tag = `if_addr[31:INDEX_W+2]`.
- Per-line storage: valid bit, tag, and 32-bit data. Only valid bits are reset.
- FSM states: IDLE, MISS, DROP.
- IDLE, `if_req`=1, `if_flush`=0:
  - Hit (valid and tag match): `if_valid`=1 and `if_inst`=data on the next cycle. Stay in IDLE.
  - Miss: latch the address and go to MISS. `mc_req`=1 and `mc_addr`={addr[31:2],2'b00} from the next cycle.
- MISS, `mc_flag`=1:
  - Write the line (valid=1, tag, `mc_inst`).
  - Next cycle: `if_valid`=1 and `if_inst`=`mc_inst`.
  - Drop `mc_req`, return to IDLE.
- MISS, `if_flush`=1: go to DROP. `mc_req` stays high because `mem_ctrl` cannot abort.
- DROP, `mc_flag`=1: fill the line, suppress `if_valid`, return to IDLE.
- `if_flush` in IDLE: any hit response scheduled for the next cycle is suppressed. A request on the same cycle as a flush is ignored.
- Simultaneous `mc_flag` and `if_flush` in MISS: fill the line, no `if_valid`, go to IDLE.
- New `if_req` while in MISS or DROP: not accepted until IDLE.
- `mc_flag` while in IDLE is ignored.

## Timing
- Reset (`rst`=0 at an edge): state=IDLE, all valid bits=0. `if_valid`=0, `if_inst`=0, `mc_req`=0, `mc_addr`=0.
- Reset mid-miss aborts immediately; `mem_ctrl` is reset by the same `rst`.
- Hit latency: 1 cycle from the `if_req` sample edge to `if_valid`.
- Miss latency: 1 cycle to `mc_req`, plus the `mem_ctrl` latency (5 cycles), plus 1 cycle to `if_valid`.
- `if_valid` and `mc_req` are registered outputs, high for exactly one cycle and for the whole miss respectively.
- `rdy`=0: no state, counter, or output changes. `mc_flag` is not sampled.

## Configuration
- `ICACHE_STAT_EN` defined:
  - Adds outputs `hit_cnt` and `miss_cnt` (32 bits each, reset 0, wrapping).
  - A hit increments `hit_cnt` on the cycle it is detected; entering MISS increments `miss_cnt`.
  - Flushed hits still count.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

## Structure
- Shared defines header: `ISZ`, `True`/`False`, `ICACHE_IDLE`/`ICACHE_MISS`/`ICACHE_DROP` state encodings.
- Sub-module `icache_array`: valid/tag/data storage with an asynchronous read port and a one-cycle write port. The top level holds the FSM, counters, and handshakes.

## Test plan
- Reset, then `if_req` for 0x100 with the line holding 0x00500093 → `mc_req`=1, `mc_addr`=0x100. On `mc_flag`, `if_valid`=1 and `if_inst`=0x00500093 one cycle later.
- Refetch 0x100 → `if_valid` on the next cycle, no `mc_req`.
- Fetch 0x100+(4<<INDEX_W) (same index, different tag) → miss and refill. A following fetch of 0x100 misses again.
- `if_flush` two cycles into the 0x200 miss → `mc_req` stays high until `mc_flag`, no `if_valid`. A later 0x200 fetch hits.
- `rdy`=0 for 3 cycles mid-miss with `mc_flag` pulsed while paused → no change. Completion occurs after `rdy` returns.
- With `ICACHE_STAT_EN`: 2 misses then 3 hits → `hit_cnt`=3, `miss_cnt`=2.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared types and constants for the direct-mapped instruction cache.
package icache_pkg;

  localparam int unsigned ISZ = 32;

  typedef enum logic [1:0] {
    ICACHE_IDLE = 2'd0,
    ICACHE_MISS = 2'd1,
    ICACHE_DROP = 2'd2
  } icache_state_t;

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data line storage: asynchronous read port, one-cycle write port.
module icache_array
  import icache_pkg::*;
#(
  parameter int INDEX_W = 6,
  parameter int TAG_W   = 30 - INDEX_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INDEX_W-1:0] raddr,
  output logic               rvalid,
  output logic [TAG_W-1:0]   rtag,
  output logic [ISZ-1:0]     rdata,
  input  logic               we,
  input  logic [INDEX_W-1:0] waddr,
  input  logic [TAG_W-1:0]   wtag,
  input  logic [ISZ-1:0]     wdata
);

  localparam int LINES = 1 << INDEX_W;

  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tags [LINES];
  logic [ISZ-1:0]   data [LINES];

  // Only the valid bits carry reset; tag/data are don't-care until filled.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid <= '0;
    end else if (we) begin
      valid[waddr] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      tags[waddr] <= wtag;
      data[waddr] <= wdata;
    end
  end

  assign rvalid = valid[raddr];
  assign rtag   = tags[raddr];
  assign rdata  = data[raddr];

endmodule

// File: rtl/icache.sv
// Direct-mapped one-word-per-line instruction cache in front of mem_ctrl.
// Optional hit/miss counters enabled by defining ICACHE_STAT_EN.
module icache
  import icache_pkg::*;
#(
  parameter int INDEX_W = 6
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           rdy,
  input  logic           if_req,
  input  logic [31:0]    if_addr,
  input  logic           if_flush,
  output logic           if_valid,
  output logic [ISZ-1:0] if_inst,
  output logic           mc_req,
  output logic [31:0]    mc_addr,
  input  logic           mc_flag,
  input  logic [31:0]    mc_inst
`ifdef ICACHE_STAT_EN
  ,
  output logic [31:0]    hit_cnt,
  output logic [31:0]    miss_cnt
`endif
);

  localparam int TAG_W = 30 - INDEX_W;

  icache_state_t      state;
  logic               rvalid;
  logic [TAG_W-1:0]   rtag;
  logic [ISZ-1:0]     rdata;
  logic               hit;
  logic               we;
  logic               unused_ok;

  assign unused_ok = ^if_addr[1:0];

  // Fills are addressed from the latched miss address, so a flushed or
  // redirected IF cannot retarget the in-flight write.
  assign we  = rdy && (state != ICACHE_IDLE) && mc_flag;
  assign hit = rvalid && (rtag == if_addr[31:INDEX_W+2]);

  icache_array #(
    .INDEX_W(INDEX_W),
    .TAG_W  (TAG_W)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .raddr (if_addr[INDEX_W+1:2]),
    .rvalid(rvalid),
    .rtag  (rtag),
    .rdata (rdata),
    .we    (we),
    .waddr (mc_addr[INDEX_W+1:2]),
    .wtag  (mc_addr[31:INDEX_W+2]),
    .wdata (mc_inst)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= ICACHE_IDLE;
      if_valid <= 1'b0;
      if_inst  <= '0;
      mc_req   <= 1'b0;
      mc_addr  <= '0;
    end else if (rdy) begin
      if_valid <= 1'b0;
      case (state)
        ICACHE_IDLE: begin
          if (if_req && !if_flush) begin
            if (hit) begin
              if_valid <= 1'b1;
              if_inst  <= rdata;
            end else begin
              state   <= ICACHE_MISS;
              mc_req  <= 1'b1;
              mc_addr <= {if_addr[31:2], 2'b00};
            end
          end
        end
        ICACHE_MISS: begin
          if (mc_flag) begin
            state  <= ICACHE_IDLE;
            mc_req <= 1'b0;
            if (!if_flush) begin
              if_valid <= 1'b1;
              if_inst  <= mc_inst;
            end
          end else if (if_flush) begin
            state <= ICACHE_DROP;
          end
        end
        ICACHE_DROP: begin
          if (mc_flag) begin
            state  <= ICACHE_IDLE;
            mc_req <= 1'b0;
          end
        end
        default: state <= ICACHE_IDLE;
      endcase
    end
  end

`ifdef ICACHE_STAT_EN
  // A hit counts even when a same-cycle flush suppresses its response.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (rdy && state == ICACHE_IDLE && if_req) begin
      if (hit)
        hit_cnt <= hit_cnt + 32'd1;
      else if (!if_flush)
        miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif

endmodule
